// File: rtl/pipe_pkg.sv
// Shared types and helpers for the multi-stage skid pipeline.
// The stage state encoding doubles as the number of valid entries held by that stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/pipeline_skid_stage.sv
// One full-throughput skid-buffer stage: main + skid registers, registered ready,
// synchronous reset (clears everything) and flush (invalidates, keeps data).
module pipeline_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  stage_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, skid_q;
  logic                  ready_q;
  logic                  in_xfer, out_xfer;
  logic                  load_main_in, load_main_skid, load_skid;

  // ready_q always equals (state_q != ST_FULL); reset masks it while asserted
  assign in_ready  = ready_q & ~reset;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d      = ST_BUSY;
          load_main_in = 1'b1;
        end
      end
      ST_BUSY: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          state_d        = ST_BUSY;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_FULL);
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) skid_q <= in_data;
    end
  end

endmodule

// File: rtl/multi_stage_pipeline_reg.sv
// STAGES chained skid stages between producer and consumer, with synchronous flush.
// Optional macro PIPE_OCCUPANCY_EN adds a registered occupancy count output.
module multi_stage_pipeline_reg
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic                  input_valid,
  output logic                  input_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef PIPE_OCCUPANCY_EN
  ,
  output logic [occ_width(STAGES)-1:0] occupancy
`endif
);

  if (STAGES < 1) begin : g_bad_cfg
    $error("multi_stage_pipeline_reg: STAGES must be >= 1");
  end

  // Index k is the input side of stage k; index STAGES is the block output
  logic [DATA_WIDTH-1:0] chain_data [STAGES+1];
  logic [STAGES:0]       chain_valid;
  logic [STAGES:0]       chain_ready;

  assign chain_data[0]       = input_data;
  assign chain_valid[0]      = input_valid;
  assign input_ready         = chain_ready[0];
  assign out_data            = chain_data[STAGES];
  assign out_valid           = chain_valid[STAGES];
  assign chain_ready[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipeline_skid_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_data  (chain_data[k]),
      .in_valid (chain_valid[k]),
      .in_ready (chain_ready[k]),
      .out_data (chain_data[k+1]),
      .out_valid(chain_valid[k+1]),
      .out_ready(chain_ready[k+1])
    );
  end

`ifdef PIPE_OCCUPANCY_EN
  localparam int              OCC_W   = occ_width(STAGES);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(2 * STAGES);

  logic occ_in, occ_out;

  // Internal stage-to-stage moves conserve the count, so only the boundaries matter
  assign occ_in  = input_valid & input_ready;
  assign occ_out = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occupancy <= '0;
    end else begin
      case ({occ_in, occ_out})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (occupancy <= OCC_MAX);
  end
`endif

endmodule

// File: tb/tb_multi_stage_pipeline_reg.sv
// Directed + random bench for multi_stage_pipeline_reg (DATA_WIDTH=8, STAGES=3)
// with a queue scoreboard; occupancy checks compile in when PIPE_OCCUPANCY_EN is set.
module tb_multi_stage_pipeline_reg;

  localparam int DATA_WIDTH = 8;
  localparam int STAGES     = 3;
  localparam int OCC_W      = $clog2(2 * STAGES + 1);

  logic                  clk = 1'b0;
  logic                  reset, flush;
  logic [DATA_WIDTH-1:0] input_data;
  logic                  input_valid, input_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid, out_ready;
`ifdef PIPE_OCCUPANCY_EN
  logic [OCC_W-1:0]      occupancy;
`endif

  multi_stage_pipeline_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .STAGES    (STAGES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .input_data (input_data),
    .input_valid(input_valid),
    .input_ready(input_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef PIPE_OCCUPANCY_EN
    ,
    .occupancy  (occupancy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_WIDTH-1:0] data;
    int                    stamp;
  } beat_t;

  beat_t                 sb[$];
  int                    n_cmp = 0;
  int                    n_err = 0;
  int                    n_pop = 0;
  int                    cyc = 0;
  bit                    chk_lat = 0;
  bit                    prev_stall = 0;
  logic [DATA_WIDTH-1:0] prev_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: transfers seen here complete on the following rising edge
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      sb.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_data", 32'(out_data), 32'(e.data));
          if (chk_lat) check("latency", 32'(cyc - e.stamp), 32'(STAGES));
          n_pop++;
        end
      end
      if (flush) sb.delete();
      else if (input_valid && input_ready) sb.push_back('{input_data, cyc});
      prev_stall = out_valid && !out_ready && !flush;
      prev_data  = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic fill(input logic [DATA_WIDTH-1:0] base, output int accepted);
    accepted    = 0;
    out_ready   = 1'b0;
    input_valid = 1'b1;
    input_data  = base;
    for (int i = 0; i < 10; i++) begin
      bit acc;
      acc = input_ready && input_valid;
      tick();
      if (acc) begin
        accepted++;
        input_data = input_data + 8'd1;
      end
    end
  endtask

  initial begin
    int p, accepted, acc_n;
    logic ir0;
    reset       = 1'b1;
    flush       = 1'b0;
    input_valid = 1'b0;
    input_data  = '0;
    out_ready   = 1'b0;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_input_ready", 32'(input_ready), 32'd0);
`ifdef PIPE_OCCUPANCY_EN
    check("rst_occupancy", 32'(occupancy), 32'd0);
`endif
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(input_ready), 32'd1);

    // Eight back-to-back beats, consumer always ready
    p         = n_pop;
    out_ready = 1'b1;
    chk_lat   = 1;
    for (int i = 1; i <= 8; i++) begin
      input_valid = 1'b1;
      input_data  = 8'(i);
      check("stream_ready", 32'(input_ready), 32'd1);
      tick();
    end
    input_valid = 1'b0;
    wait_drain("stream_drain", 20);
    chk_lat = 0;
    check("stream_count", 32'(n_pop - p), 32'd8);

    // Stall the consumer: capacity is 2*STAGES
    fill(8'h10, accepted);
    check("fill_count", 32'(accepted), 32'd6);
    check("fill_ready", 32'(input_ready), 32'd0);
    check("fill_head", 32'(out_data), 32'h10);
`ifdef PIPE_OCCUPANCY_EN
    check("fill_occupancy", 32'(occupancy), 32'd6);
`endif
    input_valid = 1'b0;
    out_ready   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data", 32'(out_data), 32'(8'h10 + k));
      tick();
    end
    check("drain_empty", 32'(out_valid), 32'd0);

    // Random traffic, 50% valid / 50% ready
    acc_n = 0;
    for (int c = 0; c < 5000 && acc_n < 500; c++) begin
      input_valid = 1'($urandom_range(0, 1));
      input_data  = 8'($urandom);
      out_ready   = 1'($urandom_range(0, 1));
      #1;
      ir0       = input_ready;
      out_ready = ~out_ready;
      #1;
      check("ready_indep", 32'(input_ready), 32'(ir0));
      out_ready = ~out_ready;
      if (input_valid && input_ready) acc_n++;
      @(posedge clk);
      #1;
    end
    check("rand_accepted", 32'(acc_n), 32'd500);
    input_valid = 1'b0;
    out_ready   = 1'b1;
    wait_drain("rand_drain", 50);

    // Flush with four beats in flight and 0x99 offered
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      input_valid = 1'b1;
      input_data  = 8'(8'h30 + i);
      check("pre_flush_ready", 32'(input_ready), 32'd1);
      tick();
    end
    p           = n_pop;
    flush       = 1'b1;
    input_data  = 8'h99;
    out_ready   = 1'b1;
    check("flush_ready", 32'(input_ready), 32'd1);
    check("flush_head", 32'(out_data), 32'h30);
    tick();
    flush       = 1'b0;
    input_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_delivered", 32'(n_pop - p), 32'd1);
`ifdef PIPE_OCCUPANCY_EN
    check("flush_occupancy", 32'(occupancy), 32'd0);
`endif
    chk_lat     = 1;
    input_valid = 1'b1;
    input_data  = 8'hAA;
    tick();
    input_valid = 1'b0;
    wait_drain("post_flush_drain", 10);
    chk_lat = 0;
    check("post_flush_count", 32'(n_pop - p), 32'd2);
    repeat (4) tick();
    check("no_ghost_beat", 32'(out_valid), 32'd0);

    // Reset pulse on a full pipe
    fill(8'h40, accepted);
    check("fill2_count", 32'(accepted), 32'd6);
    input_valid = 1'b0;
    reset       = 1'b1;
    tick();
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_out_data", 32'(out_data), 32'h00);
    check("rst2_input_ready", 32'(input_ready), 32'd0);
`ifdef PIPE_OCCUPANCY_EN
    check("rst2_occupancy", 32'(occupancy), 32'd0);
`endif
    reset = 1'b0;
    #1;
    check("rst2_release_ready", 32'(input_ready), 32'd1);
    p           = n_pop;
    out_ready   = 1'b1;
    chk_lat     = 1;
    input_valid = 1'b1;
    input_data  = 8'h5A;
    tick();
    input_valid = 1'b0;
    wait_drain("restart_drain", 10);
    chk_lat = 0;
    check("restart_count", 32'(n_pop - p), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
